mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Multi-cycle multiply/divide unit that owns the HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs products and quotients in the background. It drives `isbusy` to the pipeline stall unit, which freezes IF/ID while an instruction in ID touches HI/LO. Results retire only after the owning instruction leaves MEM1 without exception, which keeps HI/LO precise.

## Interface
- `MUL_CYCLES`, default 1: registered multiply stages between accept and DONE.
- `DIV_ITER`, default 32: radix-2 division iterations. The value is fixed by the 32-bit width.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `EX_MDUStart` in 1: the EX-stage instruction is an MDU op.
- `EX_MDUOp` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Other codes are ignored.
- `EX_rs` in 32: rs operand, bypassed; it is the dividend or multiplicand, or the MT data.
- `EX_rt` in 32: rt operand, bypassed; it is the divisor or multiplier.
- `EX_MEM1Wr` in 1: EX→MEM1 register is advancing this cycle.
- `MEM1_MEM2Wr` in 1: MEM1→MEM2 register is advancing this cycle.
- `MEM1_Flush` in 1: exception or ERET flush is raised in MEM1 (MEM1_ex | MEM1_eret_flush).
- `HI` out 32: architectural HI.
- `LO` out 32: architectural LO.
- `isbusy` out 1: MDU is occupied, or an op is being accepted this cycle.

## Operation
- accept = `EX_MDUStart` & `EX_MEM1Wr` & ~`MEM1_Flush` & (state==IDLE).
- On accept, latch the op, `EX_rs` and `EX_rt`, and set `uncommitted`=1.
- States and transitions:
  - IDLE: on accept, go to MUL (MULT/MULTU), DIV (DIV/DIVU) or DONE (MTHI/MTLO).
  - MUL: go to DONE after `MUL_CYCLES` edges. The 64-bit product is signed or unsigned per op.
  - DIV: restoring division on |rs| and |rt| (signed ops) or raw values (unsigned ops). One quotient bit per edge; the 5-bit counter reaches DONE after 32 edges.
  - DONE: write HI/LO on the first edge where `uncommitted`=0, then go to IDLE.
  - MTHI writes only HI; MTLO writes only LO. MULT/DIV write both (HI = product[63:32] or remainder; LO = product[31:0] or quotient).
- Commit tracking: `uncommitted` clears on an edge where `MEM1_MEM2Wr`=1 and `MEM1_Flush`=0.
- Abort: if `MEM1_Flush`=1 while `uncommitted`=1, the state goes to IDLE on that edge and HI/LO are unchanged.
- After commit, a flush has no effect and the op completes.
- Signed fixup, combinational in DONE:
  - quotient is negated if sign(rs)≠sign(rt);
  - remainder takes the sign of rs.
- Divide by zero gives deterministic results:
  - unsigned: q = 0xFFFFFFFF, r = rs;
  - signed: |q| = 0xFFFFFFFF, then fixup.
- `EX_MDUStart` while state≠IDLE must not occur, because the stall unit holds the op in ID. The bench asserts this; RTL ignores it.
- `isbusy` = (state≠IDLE) | (`EX_MDUStart` & ~`MEM1_Flush`). This is combinational so that an op in EX already stalls a dependent instruction in ID.

## Timing
- Reset values: state=IDLE, HI=0, LO=0, `uncommitted`=0. `isbusy`=0 when `EX_MDUStart`=0.
- Reset mid-operation aborts immediately; no HI/LO write occurs.
- Latency from accept edge T0 to the HI/LO write edge, with no pipeline stalls:
  - MTHI/MTLO: T1.
  - MULT/MULTU: T0+`MUL_CYCLES`+1, i.e. T2 at default.
  - DIV/DIVU: T33.
- `isbusy` falls in the cycle after the write edge. New HI/LO are visible in that same cycle.
- A dcache stall holding MEM1 (`MEM1_MEM2Wr`=0) delays commit; DONE waits with HI/LO untouched and `isbusy`=1.
- `EX_MEM1Wr`=0 blocks accept, so a stalled EX op is accepted exactly once.

## Structure
- Shared package `mdu_pkg`: the op encoding constants and the state enum (IDLE, MUL, DIV, DONE).
- Sub-module `div_radix2`: the iterative restoring divider (`start`, `a`, `b`, quotient, remainder, `done`).
- The multiplier, commit logic, fixup and HI/LO registers stay in `mdu_hilo`.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3, no stalls → at T2, HI=0xFFFFFFFF, LO=0xFFFFFFFA. `isbusy`=1 in cycles 0–2.
- DIV rs=0x80000000, rt=0xFFFFFFFF → at T33, LO=0x80000000, HI=0. DIVU rs=7, rt=2 → LO=3, HI=1.
- DIV rs=−7, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=5, rt=0 → LO=0xFFFFFFFF, HI=5.
- `MEM1_Flush`=1 in the cycle after a DIV accept → state IDLE next edge, HI/LO unchanged. `MEM1_Flush` with `EX_MDUStart` → no accept.
- MTHI 0x1234 with `MEM1_MEM2Wr` held 0 for 3 cycles → HI written on the edge after `MEM1_MEM2Wr` rises. `isbusy` stays high throughout.
- Assert `rst` low at iteration 10 of a DIV → HI=LO=0 and state IDLE immediately. After release, a MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and controller states.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mdu_hilo_if.sv
// Pipeline-facing signals of the MDU: EX-stage op, pipeline advance/flush, HI/LO and busy.
interface mdu_hilo_if;
  logic        EX_MDUStart;
  logic [2:0]  EX_MDUOp;
  logic [31:0] EX_rs;
  logic [31:0] EX_rt;
  logic        EX_MEM1Wr;
  logic        MEM1_MEM2Wr;
  logic        MEM1_Flush;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        isbusy;

  modport master (
    output EX_MDUStart, EX_MDUOp, EX_rs, EX_rt, EX_MEM1Wr, MEM1_MEM2Wr, MEM1_Flush,
    input  HI, LO, isbusy
  );

  modport slave (
    input  EX_MDUStart, EX_MDUOp, EX_rs, EX_rt, EX_MEM1Wr, MEM1_MEM2Wr, MEM1_Flush,
    output HI, LO, isbusy
  );
endinterface

// File: rtl/div_radix2.sv
// Iterative unsigned restoring divider: one quotient bit per clock, ITER iterations after start.
module div_radix2 #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0] r_rem, r_quo, r_div;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic [32:0] w_shift;
  logic [33:0] w_diff;
  logic        w_ge;

  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_div};
  assign w_ge    = ~w_diff[33];
  // High during the cycle whose closing edge computes the last quotient bit.
  assign done    = r_busy & (r_cnt == 5'(ITER - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_rem  <= '0;
      r_quo  <= a;
      r_div  <= b;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_ge ? w_diff[31:0] : w_shift[31:0];
      r_quo  <= {r_quo[30:0], w_ge};
      r_cnt  <= r_cnt + 5'd1;
      if (done) r_busy <= 1'b0;
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning HI/LO; results retire only once the owning op leaves MEM1 unflushed.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 1,
  parameter int DIV_ITER   = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_hilo_if.slave  bus
);

  localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_t           r_state, w_state_next;
  logic [2:0]       r_op;
  logic [31:0]      r_rs, r_rt, r_hi, r_lo;
  logic             r_unc;
  logic [MCW-1:0]   r_mcnt;

  logic             w_accept, w_ex_signed, w_div_start, w_div_done;
  logic             w_commit_now, w_abort, w_write, w_mul_signed, w_div_signed;
  logic [31:0]      w_div_a, w_div_b, w_div_q, w_div_r, w_quo, w_rem;
  logic signed [32:0] w_ma, w_mb;
  logic signed [65:0] w_mfull;
  logic [63:0]      w_mchain [MUL_CYCLES+1];

  assign w_accept = bus.EX_MDUStart & bus.EX_MEM1Wr & ~bus.MEM1_Flush &
                    (r_state == IDLE) & (bus.EX_MDUOp <= OP_MTLO);
  assign w_ex_signed = (bus.EX_MDUOp == OP_DIV);
  assign w_div_start = w_accept & ((bus.EX_MDUOp == OP_DIV) | (bus.EX_MDUOp == OP_DIVU));
  assign w_div_a = (w_ex_signed & bus.EX_rs[31]) ? -bus.EX_rs : bus.EX_rs;
  assign w_div_b = (w_ex_signed & bus.EX_rt[31]) ? -bus.EX_rt : bus.EX_rt;

  div_radix2 #(.ITER(DIV_ITER)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .a         (w_div_a),
    .b         (w_div_b),
    .quotient  (w_div_q),
    .remainder (w_div_r),
    .done      (w_div_done)
  );

  // 33-bit signed operands cover both MULT and MULTU with one multiplier.
  assign w_mul_signed = (r_op == OP_MULT);
  assign w_ma    = {w_mul_signed & r_rs[31], r_rs};
  assign w_mb    = {w_mul_signed & r_rt[31], r_rt};
  assign w_mfull = w_ma * w_mb;
  assign w_mchain[0] = w_mfull[63:0];

  genvar gi;
  generate
    for (gi = 0; gi < MUL_CYCLES; gi++) begin : g_mstage
      logic [63:0] r_stage;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_stage <= '0;
        else      r_stage <= w_mchain[gi];
      end
      assign w_mchain[gi+1] = r_stage;
    end
  endgenerate

  assign w_div_signed = (r_op == OP_DIV);
  assign w_quo = (w_div_signed & (r_rs[31] ^ r_rt[31])) ? -w_div_q : w_div_q;
  assign w_rem = (w_div_signed & r_rs[31]) ? -w_div_r : w_div_r;

  // A commit arriving on the same edge as DONE retires immediately.
  assign w_commit_now = ~r_unc | (bus.MEM1_MEM2Wr & ~bus.MEM1_Flush);
  assign w_abort      = r_unc & bus.MEM1_Flush;
  assign w_write      = (r_state == DONE) & w_commit_now;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (bus.EX_MDUOp)
            OP_MULT, OP_MULTU: w_state_next = MUL;
            OP_DIV, OP_DIVU:   w_state_next = DIV;
            default:           w_state_next = DONE;
          endcase
        end
      end
      MUL:  if (r_mcnt == MCW'(MUL_CYCLES - 1)) w_state_next = DONE;
      DIV:  if (w_div_done) w_state_next = DONE;
      DONE: if (w_commit_now) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_abort) w_state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op   <= '0;
      r_rs   <= '0;
      r_rt   <= '0;
      r_mcnt <= '0;
      r_unc  <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= bus.EX_MDUOp;
        r_rs   <= bus.EX_rs;
        r_rt   <= bus.EX_rt;
        r_mcnt <= '0;
      end else if (r_state == MUL) begin
        r_mcnt <= r_mcnt + MCW'(1);
      end

      if (w_accept)                                r_unc <= 1'b1;
      else if (bus.MEM1_Flush | bus.MEM1_MEM2Wr)   r_unc <= 1'b0;

      if (w_write) begin
        case (r_op)
          OP_MTHI:           r_hi <= r_rs;
          OP_MTLO:           r_lo <= r_rs;
          OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_mchain[MUL_CYCLES];
          default: begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        endcase
      end
    end
  end

  assign bus.HI     = r_hi;
  assign bus.LO     = r_lo;
  assign bus.isbusy = (r_state != IDLE) | (bus.EX_MDUStart & ~bus.MEM1_Flush);

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomized and directed checks of mdu_hilo against an arithmetic HI/LO model.
module tb_mdu_hilo;

  localparam int MUL_CYCLES = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mdu_hilo_if bus();

  mdu_hilo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: architectural effect of one op on HI/LO from plain arithmetic.
  function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin sp = sa * sb; exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
      3'd1: begin up = ua * ub; exp_hi = up[63:32]; exp_lo = up[31:0]; end
      3'd2: begin
        if (b == 0) begin
          exp_lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
          exp_hi = a;
        end else begin
          sq = sa / sb; sr = sa % sb;
          exp_lo = sq[31:0]; exp_hi = sr[31:0];
        end
      end
      3'd3: begin
        if (b == 0) begin exp_lo = 32'hFFFF_FFFF; exp_hi = a; end
        else begin up = ua / ub; exp_lo = up[31:0]; up = ua % ub; exp_hi = up[31:0]; end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  function automatic int op_latency(input logic [2:0] op);
    if (op >= 3'd4) return 1;
    if (op <= 3'd1) return MUL_CYCLES + 1;
    return 33;
  endfunction

  // Entered and left just after a falling edge with the unit idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] old_hi, old_lo;
    int n, hold_bad;
    check_val("idle_before_issue", {63'b0, bus.isbusy}, 64'd0);
    old_hi = exp_hi;
    old_lo = exp_lo;
    model_op(op, a, b);
    bus.EX_MDUStart = 1'b1;
    bus.EX_MDUOp    = op;
    bus.EX_rs       = a;
    bus.EX_rt       = b;
    bus.EX_MEM1Wr   = 1'b1;
    bus.MEM1_MEM2Wr = 1'b1;
    bus.MEM1_Flush  = 1'b0;
    #1;
    check_val("busy_on_accept", {63'b0, bus.isbusy}, 64'd1);
    @(posedge clk);
    #1;
    bus.EX_MDUStart = 1'b0;
    bus.EX_rs       = $urandom();
    bus.EX_rt       = $urandom();
    n = 0;
    hold_bad = 0;
    @(negedge clk);
    while (bus.isbusy && n < 100) begin
      if (bus.HI !== old_hi || bus.LO !== old_lo) hold_bad++;
      n++;
      @(negedge clk);
    end
    check_val("busy_cycles", 64'(n), 64'(op_latency(op)));
    check_val("hilo_hold", 64'(hold_bad), 64'd0);
    check_val("hi", {32'b0, bus.HI}, {32'b0, exp_hi});
    check_val("lo", {32'b0, bus.LO}, {32'b0, exp_lo});
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h busy=%0d", op, a, b, bus.HI, bus.LO, n);
  endtask

  initial begin
    bus.EX_MDUStart = 1'b0;
    bus.EX_MDUOp    = 3'd0;
    bus.EX_rs       = '0;
    bus.EX_rt       = '0;
    bus.EX_MEM1Wr   = 1'b1;
    bus.MEM1_MEM2Wr = 1'b1;
    bus.MEM1_Flush  = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_val("reset_hi", {32'b0, bus.HI}, 64'd0);
    check_val("reset_lo", {32'b0, bus.LO}, 64'd0);
    check_val("reset_busy", {63'b0, bus.isbusy}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    check_val("tp_mult_hi", {32'b0, bus.HI}, 64'hFFFF_FFFF);
    check_val("tp_mult_lo", {32'b0, bus.LO}, 64'hFFFF_FFFA);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check_val("tp_div_ovf_lo", {32'b0, bus.LO}, 64'h8000_0000);
    run_op(3'd3, 32'd7, 32'd2);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    check_val("tp_div_neg_lo", {32'b0, bus.LO}, 64'hFFFF_FFFD);
    check_val("tp_div_neg_hi", {32'b0, bus.HI}, 64'hFFFF_FFFF);
    run_op(3'd3, 32'd5, 32'd0);
    check_val("tp_divu0_lo", {32'b0, bus.LO}, 64'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0);
    run_op(3'd4, 32'hCAFE_0001, 32'd0);
    run_op(3'd5, 32'hBEEF_0002, 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 5)), rand_operand(), rand_operand());
    end

    // Flush in the cycle after a DIV accept aborts it.
    bus.EX_MDUStart = 1'b1; bus.EX_MDUOp = 3'd2; bus.EX_rs = 32'd100; bus.EX_rt = 32'd7;
    @(posedge clk); #1;
    bus.EX_MDUStart = 1'b0; bus.MEM1_Flush = 1'b1; bus.MEM1_MEM2Wr = 1'b0;
    @(negedge clk);
    check_val("flush_busy_before", {63'b0, bus.isbusy}, 64'd1);
    @(posedge clk); #1;
    bus.MEM1_Flush = 1'b0; bus.MEM1_MEM2Wr = 1'b1;
    @(negedge clk);
    check_val("flush_idle", {63'b0, bus.isbusy}, 64'd0);
    repeat (40) @(negedge clk);
    check_val("flush_hi", {32'b0, bus.HI}, {32'b0, exp_hi});
    check_val("flush_lo", {32'b0, bus.LO}, {32'b0, exp_lo});
    $display("div aborted by flush -> hi=%h lo=%h", bus.HI, bus.LO);

    // Flush alongside a start blocks the accept.
    bus.EX_MDUStart = 1'b1; bus.EX_MDUOp = 3'd4; bus.EX_rs = 32'hDEAD_0000; bus.MEM1_Flush = 1'b1;
    #1;
    check_val("flush_start_busy", {63'b0, bus.isbusy}, 64'd0);
    @(posedge clk); #1;
    bus.EX_MDUStart = 1'b0; bus.MEM1_Flush = 1'b0;
    repeat (3) @(negedge clk);
    check_val("flush_start_noacc", {32'b0, bus.HI}, {32'b0, exp_hi});
    $display("mthi with flush -> hi=%h", bus.HI);

    // Unknown opcode is ignored.
    bus.EX_MDUStart = 1'b1; bus.EX_MDUOp = 3'd7; bus.EX_rs = 32'h1111_2222;
    @(posedge clk); #1;
    bus.EX_MDUStart = 1'b0;
    @(negedge clk);
    check_val("badop_idle", {63'b0, bus.isbusy}, 64'd0);
    check_val("badop_lo", {32'b0, bus.LO}, {32'b0, exp_lo});
    $display("op=7 ignored -> busy=%0d", bus.isbusy);

    // MTHI held in MEM1 by a stall retires on the edge after MEM2 write rises.
    bus.EX_MDUStart = 1'b1; bus.EX_MDUOp = 3'd4; bus.EX_rs = 32'h0000_1234;
    @(posedge clk); #1;
    bus.EX_MDUStart = 1'b0; bus.MEM1_MEM2Wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("stall_busy", {63'b0, bus.isbusy}, 64'd1);
      check_val("stall_hi_hold", {32'b0, bus.HI}, {32'b0, exp_hi});
      @(posedge clk); #1;
    end
    bus.MEM1_MEM2Wr = 1'b1;
    @(negedge clk);
    check_val("stall_hi_before", {32'b0, bus.HI}, {32'b0, exp_hi});
    @(negedge clk);
    exp_hi = 32'h0000_1234;
    check_val("stall_hi_written", {32'b0, bus.HI}, {32'b0, exp_hi});
    check_val("stall_busy_end", {63'b0, bus.isbusy}, 64'd0);
    $display("mthi after stall -> hi=%h", bus.HI);

    // EX stalled: op waits until EX_MEM1Wr, then retires once.
    bus.EX_MDUStart = 1'b1; bus.EX_MDUOp = 3'd5; bus.EX_rs = 32'h55AA_55AA; bus.EX_MEM1Wr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val("exstall_lo_hold", {32'b0, bus.LO}, {32'b0, exp_lo});
    end
    bus.EX_MEM1Wr = 1'b1;
    @(posedge clk); #1;
    bus.EX_MDUStart = 1'b0;
    @(negedge clk);
    check_val("exstall_busy", {63'b0, bus.isbusy}, 64'd1);
    @(negedge clk);
    exp_lo = 32'h55AA_55AA;
    check_val("exstall_lo", {32'b0, bus.LO}, {32'b0, exp_lo});
    check_val("exstall_idle", {63'b0, bus.isbusy}, 64'd0);
    $display("mtlo after ex stall -> lo=%h", bus.LO);

    // Reset during a DIV clears everything at once.
    bus.EX_MDUStart = 1'b1; bus.EX_MDUOp = 3'd2; bus.EX_rs = 32'd1000; bus.EX_rt = 32'd3;
    @(posedge clk); #1;
    bus.EX_MDUStart = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check_val("midrst_hi", {32'b0, bus.HI}, 64'd0);
    check_val("midrst_lo", {32'b0, bus.LO}, 64'd0);
    check_val("midrst_busy", {63'b0, bus.isbusy}, 64'd0);
    $display("reset mid-div -> hi=%h lo=%h", bus.HI, bus.LO);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_val("tp_multu_hi", {32'b0, bus.HI}, 64'hFFFF_FFFE);
    check_val("tp_multu_lo", {32'b0, bus.LO}, 64'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
